// File: rtl/vga_timing_gen.sv
// VGA timing and test-pattern generator with programmable porches, sync polarity and pixel divide.
// One register stage turns the (h, v, div) counters into mutually aligned sync/de/x/y/rgb outputs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 1,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic                                               _i_clk,
    input  logic                                               _i_rst,
    input  logic [1:0]                                         _i_mode,
    input  logic [3*COLOR_W-1:0]                               _i_color,
    output logic                                               hsync,
    output logic                                               vsync,
    output logic                                               de,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       y,
    output logic [COLOR_W-1:0]                                 r,
    output logic [COLOR_W-1:0]                                 g,
    output logic [COLOR_W-1:0]                                 b,
    output logic                                               frame_start,
    output logic [15:0]                                        frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW       = $clog2(H_TOTAL);
    localparam int unsigned YW       = $clog2(V_TOTAL);
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [DW-1:0]      div;
    logic [XW-1:0]      h;
    logic [YW-1:0]      v;
    logic [1:0]         mode_q;

    logic [31:0]        hh;
    logic [31:0]        vv;
    logic [31:0]        bar;
    logic [2:0]         bar_k;
    logic               tick;
    logic               h_last;
    logic               v_last;
    logic               at_origin;
    logic               hs_act;
    logic               vs_act;
    logic               de_c;
    logic [1:0]         mode_c;
    logic [COLOR_W-1:0] r_c;
    logic [COLOR_W-1:0] g_c;
    logic [COLOR_W-1:0] b_c;

    // Pixel timing decode and pattern selection for the current (h, v)
    always_comb begin
        hh        = 32'(h);
        vv        = 32'(v);
        tick      = (32'(div) == CLK_DIV - 1);
        h_last    = (hh == H_TOTAL - 1);
        v_last    = (vv == V_TOTAL - 1);
        at_origin = (hh == 32'd0) && (vv == 32'd0);
        hs_act    = (hh >= HS_START) && (hh < HS_END);
        vs_act    = (vv >= VS_START) && (vv < VS_END);
        de_c      = (hh < H_ACTIVE) && (vv < V_ACTIVE);
        // Pixel (0,0) already shows the mode that is about to be latched for the frame
        mode_c    = at_origin ? _i_mode : mode_q;
        bar       = hh / BAR_W;
        bar_k     = (bar > 32'd7) ? 3'd7 : bar[2:0];
        r_c       = '0;
        g_c       = '0;
        b_c       = '0;
        if (de_c) begin
            case (mode_c)
                2'd0: {r_c, g_c, b_c} = _i_color;
                2'd1: begin
                    r_c = {COLOR_W{bar_k[2]}};
                    g_c = {COLOR_W{bar_k[1]}};
                    b_c = {COLOR_W{bar_k[0]}};
                end
                2'd2: begin
                    r_c = {COLOR_W{hh[4] ^ vv[4]}};
                    g_c = {COLOR_W{hh[4] ^ vv[4]}};
                    b_c = {COLOR_W{hh[4] ^ vv[4]}};
                end
                default: ;
            endcase
        end
    end

    // Pixel divider, raster counters, per-frame mode latch and frame counter
    always_ff @(posedge _i_clk) begin
        if (!_i_rst) begin
            div       <= '0;
            h         <= '0;
            v         <= '0;
            mode_q    <= 2'd0;
            frame_cnt <= 16'd0;
        end else if (tick) begin
            div <= '0;
            if (at_origin) begin
                mode_q <= _i_mode;
            end
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v         <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    v <= v + YW'(1);
                end
            end else begin
                h <= h + XW'(1);
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    // Output register stage
    always_ff @(posedge _i_clk) begin
        if (!_i_rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            de          <= de_c;
            x           <= h;
            y           <= v;
            r           <= r_c;
            g           <= g_c;
            b           <= b_c;
            frame_start <= tick && at_origin;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: five parameter sets share clock, reset, mode and colour;
// expected rasters come from clock-count arithmetic and are checked on the falling edge.
module tb_vga_timing_gen;

    localparam int NI = 5;
    localparam int unsigned HA [NI] = '{8, 8, 16, 32, 640};
    localparam int unsigned HF [NI] = '{2, 2, 2, 4, 16};
    localparam int unsigned HS [NI] = '{2, 2, 2, 4, 96};
    localparam int unsigned HB [NI] = '{2, 2, 2, 4, 48};
    localparam int unsigned VA [NI] = '{4, 4, 4, 20, 480};
    localparam int unsigned VF [NI] = '{1, 1, 1, 2, 10};
    localparam int unsigned VS [NI] = '{1, 1, 1, 2, 2};
    localparam int unsigned VB [NI] = '{1, 1, 1, 2, 33};
    localparam int unsigned HP [NI] = '{0, 0, 0, 1, 0};
    localparam int unsigned VP [NI] = '{0, 0, 1, 0, 0};
    localparam int unsigned CW [NI] = '{1, 1, 2, 8, 1};
    localparam int unsigned DV [NI] = '{1, 3, 1, 2, 1};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    typedef exp_t [NI-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [23:0] color;
    exp_t        act [NI];
    row_t        expq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int unsigned XWI = $clog2(HA[gi] + HF[gi] + HS[gi] + HB[gi]);
        localparam int unsigned YWI = $clog2(VA[gi] + VF[gi] + VS[gi] + VB[gi]);
        localparam int unsigned CWI = CW[gi];
        logic           hs_w, vs_w, de_w, fs_w;
        logic [XWI-1:0] x_w;
        logic [YWI-1:0] y_w;
        logic [CWI-1:0] r_w, g_w, b_w;
        logic [15:0]    fc_w;

        vga_timing_gen #(
            .H_ACTIVE(HA[gi]), .H_FP(HF[gi]), .H_SYNC(HS[gi]), .H_BP(HB[gi]),
            .V_ACTIVE(VA[gi]), .V_FP(VF[gi]), .V_SYNC(VS[gi]), .V_BP(VB[gi]),
            .HS_POL(1'(HP[gi])), .VS_POL(1'(VP[gi])),
            .COLOR_W(CW[gi]), .CLK_DIV(DV[gi])
        ) u_dut (
            ._i_clk     (clk),
            ._i_rst     (rst_n),
            ._i_mode    (mode),
            ._i_color   (color[3*CWI-1:0]),
            .hsync      (hs_w),
            .vsync      (vs_w),
            .de         (de_w),
            .x          (x_w),
            .y          (y_w),
            .r          (r_w),
            .g          (g_w),
            .b          (b_w),
            .frame_start(fs_w),
            .frame_cnt  (fc_w)
        );

        assign act[gi] = {hs_w, vs_w, de_w, 16'(x_w), 16'(y_w), 8'(r_w), 8'(g_w), 8'(b_w), fs_w, fc_w};
    end

    function automatic int unsigned ht(int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int unsigned vt(int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    function automatic exp_t idle_exp(int i);
        exp_t e;
        e    = '0;
        e.hs = (HP[i] == 0);
        e.vs = (VP[i] == 0);
        return e;
    endfunction

    // Expected outputs k clocks after reset release, from the raster arithmetic
    function automatic exp_t model(int i, int unsigned k, logic [1:0] md, logic [23:0] col);
        exp_t        e;
        int unsigned htot = ht(i);
        int unsigned vtot = vt(i);
        int unsigned p    = k / DV[i];
        int unsigned hpos = p % htot;
        int unsigned vpos = (p / htot) % vtot;
        int unsigned ones = (32'd1 << CW[i]) - 1;
        int unsigned bar;
        int unsigned on;
        e    = '0;
        e.hs = ((hpos >= HA[i] + HF[i]) && (hpos < HA[i] + HF[i] + HS[i])) ? (HP[i] != 0) : (HP[i] == 0);
        e.vs = ((vpos >= VA[i] + VF[i]) && (vpos < VA[i] + VF[i] + VS[i])) ? (VP[i] != 0) : (VP[i] == 0);
        e.de = (hpos < HA[i]) && (vpos < VA[i]);
        e.x  = 16'(hpos);
        e.y  = 16'(vpos);
        if (e.de) begin
            case (md)
                2'd0: begin
                    e.r = 8'((32'(col) >> (2 * CW[i])) & ones);
                    e.g = 8'((32'(col) >> CW[i]) & ones);
                    e.b = 8'(32'(col) & ones);
                end
                2'd1: begin
                    bar = hpos / (HA[i] / 8);
                    if (bar > 7) bar = 7;
                    e.r = ((bar & 4) != 0) ? 8'(ones) : 8'd0;
                    e.g = ((bar & 2) != 0) ? 8'(ones) : 8'd0;
                    e.b = ((bar & 1) != 0) ? 8'(ones) : 8'd0;
                end
                2'd2: begin
                    on  = ((hpos / 16) + (vpos / 16)) % 2;
                    e.r = (on != 0) ? 8'(ones) : 8'd0;
                    e.g = e.r;
                    e.b = e.r;
                end
                default: ;
            endcase
        end
        e.fs = ((k % DV[i]) == DV[i] - 1) && ((p % (htot * vtot)) == 0);
        e.fc = 16'(((k + 1) / (DV[i] * htot * vtot)) % 65536);
        return e;
    endfunction

    int unsigned kcnt   [NI];
    logic [1:0]  mode_f [NI];

    // Reference model: one expected row per rising edge
    always @(posedge clk) begin
        row_t       row;
        logic [1:0] md;
        bit         at0;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                row[i]    = idle_exp(i);
                kcnt[i]   = 0;
                mode_f[i] = 2'd0;
            end else begin
                at0 = ((kcnt[i] / DV[i]) % (ht(i) * vt(i))) == 0;
                md  = at0 ? mode : mode_f[i];
                if (at0 && ((kcnt[i] % DV[i]) == DV[i] - 1)) mode_f[i] = mode;
                row[i]  = model(i, kcnt[i], md, color);
                kcnt[i] = kcnt[i] + 1;
            end
        end
        expq.push_back(row);
    end

    task automatic chk(input int i, input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL inst%0d %s at %0t: got %0h expected %0h", i, nm, $time, a, e);
        end
    endtask

    // Monitor: compare every instance against the oldest expected row
    always @(negedge clk) begin
        row_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at %0t: got 0 rows expected 1", $time);
        end else begin
            e = expq.pop_front();
            for (int i = 0; i < NI; i++) begin
                chk(i, "hsync",       32'(act[i].hs), 32'(e[i].hs));
                chk(i, "vsync",       32'(act[i].vs), 32'(e[i].vs));
                chk(i, "de",          32'(act[i].de), 32'(e[i].de));
                chk(i, "x",           32'(act[i].x),  32'(e[i].x));
                chk(i, "y",           32'(act[i].y),  32'(e[i].y));
                chk(i, "r",           32'(act[i].r),  32'(e[i].r));
                chk(i, "g",           32'(act[i].g),  32'(e[i].g));
                chk(i, "b",           32'(act[i].b),  32'(e[i].b));
                chk(i, "frame_start", 32'(act[i].fs), 32'(e[i].fs));
                chk(i, "frame_cnt",   32'(act[i].fc), 32'(e[i].fc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        mode  = 2'd0;
        color = 24'h000007;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            mode = (seg < 4) ? 2'(seg) : 2'($urandom);
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk);
                #1;
                if (seg > 0) color = 24'($urandom);
                if (seg >= 4 && $urandom_range(0, 299) == 0) mode = 2'($urandom);
                rst_n = !((seg == 5 && c == 700) || $urandom_range(0, 2999) == 0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
